bcd_modn_counter: RTL and testbench
===================================

BCD_MODN_COUNTER -- requirements
Module: bcd_modn_counter

Interface
REQ-001 Parameter DIGITS, default 2, number of BCD digits (legal 1..4).
REQ-002 Parameter MODULUS, default 60, count modulus (legal 2..10**DIGITS).
REQ-003 Parameter SAT, default 0: 0 = wrap at the count boundaries, 1 = saturate (hold) at them.
REQ-004 CP  input  1  clock; all state SHALL update on the rising edge only.
REQ-005 CLR  input  1  synchronous, active-high reset.
REQ-006 LD  input  1  synchronous parallel load of D.
REQ-007 EN  input  1  local count enable.
REQ-008 CI  input  1  cascade carry-in; the counter SHALL count only when EN=1 and CI=1.
REQ-009 DIR  input  1  count direction: 1 = up, 0 = down.
REQ-010 D  input  4*DIGITS  BCD load value, least significant digit in D[3:0].
REQ-011 Q  output  4*DIGITS  registered BCD count.
REQ-012 CO  output  1  combinational terminal-count / cascade carry-out.
REQ-013 ERR  output  1  registered one-cycle pulse flagging a rejected load.

Function
REQ-014 Priority per edge SHALL be CLR, then LD, then count, then hold.
REQ-015 Count step SHALL use digit-wise BCD arithmetic.
  - Up: a digit at 9 becomes 0 and carries into the next digit.
  - Down: a digit at 0 becomes 9 and borrows from the next digit.
  - Q digits SHALL never hold 0xA-0xF.
REQ-016 Up count at Q==MODULUS-1 (BCD-encoded) SHALL give Q=0 when SAT=0, and hold Q when SAT=1.
REQ-017 Down count at Q==0 SHALL give Q=MODULUS-1 when SAT=0, and hold Q when SAT=1.
REQ-018 CO SHALL equal EN & CI & ((DIR & Q==MODULUS-1) | (~DIR & Q==0)), independent of SAT, LD and CLR.
REQ-019 A load is valid when every digit of D is <=9 and value(D) < MODULUS.
  - Valid load: Q SHALL take D on the next edge.
  - Invalid load: Q SHALL take 0 and ERR SHALL be 1 for exactly the following cycle.
REQ-020 ERR SHALL be 0 in every cycle that does not follow an invalid load edge.
REQ-021 DIR changes SHALL take effect on the very next counting edge, with no pipeline delay.
REQ-022 Cascading SHALL need no extra logic: connecting lower CO to upper CI, with shared EN and DIR, SHALL form a single combined modulus counter (e.g. 60 then 24 gives 1440).
REQ-023 With EN=0 or CI=0 and LD=0, Q SHALL hold and CO SHALL be 0.
REQ-024 Parameter values outside the legal ranges SHALL stop elaboration (simulation fatal).

Reset
REQ-025 On a CP edge with CLR=1, Q SHALL become 0 and ERR SHALL become 0, regardless of LD, EN, CI, DIR and D.
REQ-026 CLR asserted in the middle of a count sequence SHALL take effect on that edge; counting SHALL resume from 0 on the first edge after CLR falls, provided EN&CI=1.
REQ-027 No output SHALL change without a CP edge, except CO, which follows EN, CI, DIR and Q combinationally.

Verification
REQ-028 Reset and basic up count (DIGITS=2, MODULUS=60, SAT=0)
  - Stimulus: CLR=1 for 1 edge, then EN=CI=DIR=1.
  - Response: Q=0x00, then 0x01, 0x02, ...
  - At Q=0x59: CO=1, then Q=0x00 on the next edge.
REQ-029 Down wrap (same configuration)
  - Stimulus: DIR=0 at Q=0x00.
  - Response: CO=1, next Q=0x59, then 0x58.
  - At Q=0x10, the next Q is 0x09 (BCD borrow).
REQ-030 Load checks
  - LD=1, D=0x45: next Q=0x45, ERR=0.
  - LD=1, D=0x7A: next Q=0x00, ERR=1 for one cycle.
  - LD=1, D=0x60: next Q=0x00, ERR=1 for one cycle.
  - CLR=1 and LD=1 on the same edge with D=0x45: Q=0x00, ERR=0.
REQ-031 Saturate mode (MODULUS=24, SAT=1)
  - Up at Q=0x23: Q holds 0x23 with CO=1.
  - Down at Q=0x00: Q holds 0x00 with CO=1.
  - EN=0: CO=0.
REQ-032 Cascade: a MODULUS=60 instance feeding a MODULUS=24 instance (CO to CI), EN=1.
  - Up: after 1440 edges from 00:00, both read 00:00.
  - Up: at 23:59, both CO=1.
  - Then DIR=0 for 1 edge: reads 23:59.

Source files
------------

// File: rtl/bcd_modn_counter.sv
// bcd_modn_counter: parameterised multi-digit BCD up/down counter with a
// programmable modulus, optional saturation at the count boundaries,
// validated synchronous parallel load and a combinational carry-out that
// lets instances be chained into one larger modulus counter.
module bcd_modn_counter #(
   parameter int DIGITS  = 2,
   parameter int MODULUS = 60,
   parameter int SAT     = 0
) (
   input  logic                  CP,
   input  logic                  CLR,
   input  logic                  LD,
   input  logic                  EN,
   input  logic                  CI,
   input  logic                  DIR,
   input  logic [4*DIGITS-1:0]   D,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  CO,
   output logic                  ERR
);

   localparam int DATA_W = 4 * DIGITS;

   // 10**n as a constant function so the modulus range check elaborates.
   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   // Binary-to-BCD conversion of an elaboration-time constant.
   function automatic logic [DATA_W-1:0] to_bcd(input int v);
      logic [DATA_W-1:0] r;
      int               rem;
      r   = '0;
      rem = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(rem % 10);
         rem         = rem / 10;
      end
      return r;
   endfunction

   localparam int                RANGE = pow10(DIGITS);
   localparam logic [DATA_W-1:0] TOP   = to_bcd(MODULUS - 1);

   // Illegal parameter combinations stop elaboration outright.
   if (DIGITS < 1 || DIGITS > 4 || MODULUS < 2 || MODULUS > RANGE ||
       SAT < 0 || SAT > 1) begin : g_param_check
      $fatal(1, "bcd_modn_counter: illegal DIGITS/MODULUS/SAT");
   end

   // True when no digit holds a non-decimal code (0xA-0xF).
   function automatic logic digits_valid(input logic [DATA_W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Decimal value of a BCD word; only meaningful when digits_valid holds.
   function automatic int bcd_value(input logic [DATA_W-1:0] v);
      int acc;
      int w;
      acc = 0;
      w   = 1;
      for (int i = 0; i < DIGITS; i++) begin
         acc = acc + w * int'(v[4*i +: 4]);
         w   = w * 10;
      end
      return acc;
   endfunction

   // Digit-wise BCD increment: a 9 rolls to 0 and carries onward.
   function automatic logic [DATA_W-1:0] bcd_inc(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      logic              c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Digit-wise BCD decrement: a 0 rolls to 9 and borrows onward.
   function automatic logic [DATA_W-1:0] bcd_dec(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      logic              b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (r[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] - 4'd1;
               b           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // One count step including the modulus boundary: wrap or saturate.
   function automatic logic [DATA_W-1:0] step_count(input logic [DATA_W-1:0] v,
                                                    input logic              up);
      logic [DATA_W-1:0] r;
      if (up) begin
         if (v == TOP) r = (SAT != 0) ? v : '0;
         else          r = bcd_inc(v);
      end else begin
         if (v == '0)  r = (SAT != 0) ? v : TOP;
         else          r = bcd_dec(v);
      end
      return r;
   endfunction

   logic [DATA_W-1:0] count_p0;
   logic              err_p0;
   logic [DATA_W-1:0] next_count;
   logic              next_err;
   logic              count_en;
   logic              load_ok;
   logic              at_top;
   logic              at_zero;

   // Terminal detection and load validation; CO is purely combinational so
   // a chained upper stage sees the carry in the same cycle.
   always_comb begin
      count_en = EN & CI;
      at_top   = (count_p0 == TOP);
      at_zero  = (count_p0 == '0);
      load_ok  = digits_valid(D) && (bcd_value(D) < MODULUS);
      CO       = count_en & ((DIR & at_top) | (~DIR & at_zero));
   end

   // Next-state selection for load / count / hold (CLR handled in the register).
   always_comb begin
      next_count = count_p0;
      next_err   = 1'b0;
      if (LD) begin
         if (load_ok) begin
            next_count = D;
         end else begin
            next_count = '0;
            next_err   = 1'b1;
         end
      end else if (count_en) begin
         next_count = step_count(count_p0, DIR);
      end
   end

   // ---- stage p0: count and error-flag registers ----
   // State register with synchronous clear taking top priority.
   always_ff @(posedge CP) begin
      if (CLR) begin
         count_p0 <= '0;
         err_p0   <= 1'b0;
      end else begin
         count_p0 <= next_count;
         err_p0   <= next_err;
      end
   end

   assign Q   = count_p0;
   assign ERR = err_p0;

endmodule

// File: tb/tb_bcd_modn_counter.sv
// tb_bcd_modn_counter: directed vector table for a mod-60 counter, plus
// hand-written sequences for saturate mode and a 60x24 cascade.
module tb_bcd_modn_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // main mod-60 wrap instance
   logic       clr = 1'b0, ld = 1'b0, en = 1'b0, ci = 1'b0, dir = 1'b0;
   logic [7:0] d = 8'h00;
   logic [7:0] q;
   logic       co, err;

   bcd_modn_counter #(.DIGITS(2), .MODULUS(60), .SAT(0)) u_m60 (
      .CP(clk), .CLR(clr), .LD(ld), .EN(en), .CI(ci), .DIR(dir),
      .D(d), .Q(q), .CO(co), .ERR(err));

   // mod-24 saturating instance
   logic       s_clr = 1'b0, s_ld = 1'b0, s_en = 1'b0, s_dir = 1'b0;
   logic [7:0] s_d = 8'h00;
   logic [7:0] s_q;
   logic       s_co, s_err;

   bcd_modn_counter #(.DIGITS(2), .MODULUS(24), .SAT(1)) u_s24 (
      .CP(clk), .CLR(s_clr), .LD(s_ld), .EN(s_en), .CI(1'b1), .DIR(s_dir),
      .D(s_d), .Q(s_q), .CO(s_co), .ERR(s_err));

   // cascade: minutes (mod 60) feeding hours (mod 24)
   logic       c_clr = 1'b0, c_en = 1'b0, c_dir = 1'b1;
   logic [7:0] lo_q, hi_q;
   logic       lo_co, hi_co, lo_err, hi_err;

   bcd_modn_counter #(.DIGITS(2), .MODULUS(60), .SAT(0)) u_lo (
      .CP(clk), .CLR(c_clr), .LD(1'b0), .EN(c_en), .CI(1'b1), .DIR(c_dir),
      .D(8'h00), .Q(lo_q), .CO(lo_co), .ERR(lo_err));

   bcd_modn_counter #(.DIGITS(2), .MODULUS(24), .SAT(0)) u_hi (
      .CP(clk), .CLR(c_clr), .LD(1'b0), .EN(c_en), .CI(lo_co), .DIR(c_dir),
      .D(8'h00), .Q(hi_q), .CO(hi_co), .ERR(hi_err));

   typedef struct {
      logic       clr, ld, en, ci, dir;
      logic [7:0] d;
      logic       chk_co;
      logic       exp_co;
      logic [7:0] exp_q;
      logic       exp_err;
   } vec_t;

   localparam int NV = 29;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic c, l, e, i, r, input logic [7:0] dv,
                               input logic kc, xc, input logic [7:0] xq, input logic xe);
      vec_t v;
      v.clr = c; v.ld = l; v.en = e; v.ci = i; v.dir = r; v.d = dv;
      v.chk_co = kc; v.exp_co = xc; v.exp_q = xq; v.exp_err = xe;
      return v;
   endfunction

   initial begin
      //            clr ld en ci dir  d      chk co   q      err
      vecs[0]  = mk(1, 0, 0, 0, 0, 8'h00,  0, 0, 8'h00, 0);
      vecs[1]  = mk(0, 0, 1, 1, 1, 8'h00,  1, 0, 8'h01, 0);
      vecs[2]  = mk(0, 0, 1, 1, 1, 8'h00,  1, 0, 8'h02, 0);
      vecs[3]  = mk(0, 1, 1, 1, 1, 8'h58,  1, 0, 8'h58, 0);
      vecs[4]  = mk(0, 0, 1, 1, 1, 8'h00,  1, 0, 8'h59, 0);
      vecs[5]  = mk(0, 0, 1, 1, 1, 8'h00,  1, 1, 8'h00, 0);
      vecs[6]  = mk(0, 0, 1, 1, 0, 8'h00,  1, 1, 8'h59, 0);
      vecs[7]  = mk(0, 0, 1, 1, 0, 8'h00,  1, 0, 8'h58, 0);
      vecs[8]  = mk(0, 1, 1, 1, 0, 8'h10,  1, 0, 8'h10, 0);
      vecs[9]  = mk(0, 0, 1, 1, 0, 8'h00,  1, 0, 8'h09, 0);
      vecs[10] = mk(0, 0, 1, 1, 0, 8'h00,  1, 0, 8'h08, 0);
      vecs[11] = mk(0, 0, 1, 1, 1, 8'h00,  1, 0, 8'h09, 0);
      vecs[12] = mk(0, 0, 1, 1, 1, 8'h00,  1, 0, 8'h10, 0);
      vecs[13] = mk(0, 0, 0, 1, 1, 8'h00,  1, 0, 8'h10, 0);
      vecs[14] = mk(0, 0, 1, 0, 1, 8'h00,  1, 0, 8'h10, 0);
      vecs[15] = mk(0, 1, 0, 0, 1, 8'h45,  1, 0, 8'h45, 0);
      vecs[16] = mk(0, 1, 0, 0, 1, 8'h7A,  1, 0, 8'h00, 1);
      vecs[17] = mk(0, 0, 0, 0, 1, 8'h00,  1, 0, 8'h00, 0);
      vecs[18] = mk(0, 1, 0, 0, 1, 8'h60,  1, 0, 8'h00, 1);
      vecs[19] = mk(0, 0, 1, 1, 1, 8'h00,  1, 0, 8'h01, 0);
      vecs[20] = mk(0, 1, 0, 0, 1, 8'h59,  1, 0, 8'h59, 0);
      vecs[21] = mk(1, 0, 1, 1, 1, 8'h00,  1, 1, 8'h00, 0);
      vecs[22] = mk(1, 1, 0, 0, 1, 8'h45,  1, 0, 8'h00, 0);
      vecs[23] = mk(0, 1, 0, 0, 1, 8'hA5,  1, 0, 8'h00, 1);
      vecs[24] = mk(1, 1, 0, 0, 1, 8'h7A,  1, 0, 8'h00, 0);
      vecs[25] = mk(0, 1, 0, 0, 1, 8'h59,  1, 0, 8'h59, 0);
      vecs[26] = mk(0, 0, 0, 1, 1, 8'h00,  1, 0, 8'h59, 0);
      vecs[27] = mk(0, 0, 1, 0, 1, 8'h00,  1, 0, 8'h59, 0);
      vecs[28] = mk(0, 0, 1, 1, 0, 8'h00,  1, 0, 8'h58, 0);

      // ---- table-driven mod-60 checks ----
      for (int k = 0; k < NV; k++) begin
         clr = vecs[k].clr; ld = vecs[k].ld; en = vecs[k].en;
         ci  = vecs[k].ci;  dir = vecs[k].dir; d = vecs[k].d;
         #1;
         if (vecs[k].chk_co) check($sformatf("m60 co row%0d", k), 32'(co), 32'(vecs[k].exp_co));
         tick();
         check($sformatf("m60 q row%0d", k), 32'(q), 32'(vecs[k].exp_q));
         check($sformatf("m60 err row%0d", k), 32'(err), 32'(vecs[k].exp_err));
      end
      clr = 1'b0; ld = 1'b0; en = 1'b0; ci = 1'b0;

      // ---- saturate mode, modulus 24 ----
      s_clr = 1'b1; tick(); s_clr = 1'b0;
      check("s24 q reset", 32'(s_q), 32'h00);
      check("s24 err reset", 32'(s_err), 32'h0);
      s_ld = 1'b1; s_d = 8'h23; tick(); s_ld = 1'b0;
      check("s24 q load23", 32'(s_q), 32'h23);
      s_en = 1'b1; s_dir = 1'b1; #1;
      check("s24 co top up", 32'(s_co), 32'h1);
      tick(); check("s24 q hold top 1", 32'(s_q), 32'h23);
      tick(); check("s24 q hold top 2", 32'(s_q), 32'h23);
      s_dir = 1'b0; #1;
      check("s24 co top down", 32'(s_co), 32'h0);
      tick(); check("s24 q 22", 32'(s_q), 32'h22);
      s_ld = 1'b1; s_d = 8'h00; tick(); s_ld = 1'b0;
      check("s24 q load00", 32'(s_q), 32'h00);
      check("s24 co zero down", 32'(s_co), 32'h1);
      tick(); check("s24 q hold zero", 32'(s_q), 32'h00);
      s_en = 1'b0; #1;
      check("s24 co en0", 32'(s_co), 32'h0);
      s_ld = 1'b1; s_d = 8'h24; tick(); s_ld = 1'b0;
      check("s24 q bad load", 32'(s_q), 32'h00);
      check("s24 err bad load", 32'(s_err), 32'h1);
      tick(); check("s24 err one cycle", 32'(s_err), 32'h0);

      // ---- cascade 60 x 24 ----
      c_clr = 1'b1; tick(); c_clr = 1'b0;
      check("casc reset", 32'({hi_q, lo_q}), 32'h0000);
      c_en = 1'b1; c_dir = 1'b1;
      repeat (61) @(posedge clk);
      #1;
      check("casc 61 edges", 32'({hi_q, lo_q}), 32'h0101);
      repeat (1378) @(posedge clk);
      #1;
      check("casc 23:59", 32'({hi_q, lo_q}), 32'h2359);
      check("casc lo_co at 23:59", 32'(lo_co), 32'h1);
      check("casc hi_co at 23:59", 32'(hi_co), 32'h1);
      tick();
      check("casc 1440 edges", 32'({hi_q, lo_q}), 32'h0000);
      c_dir = 1'b0; #1;
      check("casc hi_co down at 0", 32'(hi_co), 32'h1);
      tick();
      check("casc down wrap", 32'({hi_q, lo_q}), 32'h2359);
      tick();
      check("casc down 23:58", 32'({hi_q, lo_q}), 32'h2358);
      check("casc hi_co down 23:58", 32'(hi_co), 32'h0);
      check("casc err flags", 32'({hi_err, lo_err}), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
